// File: rtl/reg_ctx_seq_if.sv
// ---------------------------------------------------------------------------
// reg_ctx_seq_if
// Bundles the context sequencer's request/status lines together with its
// register-file port (read channel 1 and write channel) and its data-memory
// port.
//
//   save_req, restore_req  core -> sequencer  start a save / restore
//   busy, done             sequencer -> core  stall while busy, done pulse
//   n1, q1                 read channel 1 index out, combinational data in
//   nd, di, reg_we         register-file write index, data, enable
//   mem_addr, mem_do       memory address and write data
//   mem_we, mem_re         memory write / read strobes
//   mem_di                 memory read data, valid the cycle after mem_re
//
// master: the sequencer side.  slave: the core / register file / memory side.
// ---------------------------------------------------------------------------
interface reg_ctx_seq_if #(
   parameter int DW = 8,
   parameter int IW = 2,
   parameter int AW = 8
);
   logic          save_req;
   logic          restore_req;
   logic          busy;
   logic          done;
   logic [IW-1:0] n1;
   logic [DW-1:0] q1;
   logic [IW-1:0] nd;
   logic [DW-1:0] di;
   logic          reg_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_do;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_di;

   modport master (
      input  save_req, restore_req, q1, mem_di,
      output busy, done, n1, nd, di, reg_we, mem_addr, mem_do, mem_we, mem_re
   );

   modport slave (
      output save_req, restore_req, q1, mem_di,
      input  busy, done, n1, nd, di, reg_we, mem_addr, mem_do, mem_we, mem_re
   );
endinterface

// File: rtl/reg_ctx_seq.sv
// ---------------------------------------------------------------------------
// reg_ctx_seq
// Context save/restore sequencer. On a save request it copies R0..R(NREG-1)
// from the register file into the memory save area at BASE..BASE+NREG-1, one
// register per cycle. On a restore request it reads each word back (read
// cycle, then register write cycle). busy stalls the core for the whole
// sequence; done pulses for one cycle at the end.
//
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   asynchronous, active-low reset
//   bus    master side of reg_ctx_seq_if (requests, status, register file
//          read channel 1 and write channel, memory port)
//
// All outputs are decoded from the current state and index, so an
// asynchronous reset drops every strobe immediately.
// ---------------------------------------------------------------------------
module reg_ctx_seq #(
   parameter int          DW   = 8,
   parameter int          IW   = 2,
   parameter int          AW   = 8,
   parameter logic [7:0]  BASE = 8'hF0
) (
   input  logic          Clock,
   input  logic          Reset,
   reg_ctx_seq_if.master bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAVE   = 3'd1,
      RST_RD = 3'd2,
      RST_WR = 3'd3,
      FIN    = 3'd4
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};
   localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);

   state_t        state_reg, state_next;
   logic [IW-1:0] idx_reg, idx_next;

   // save-area address; the sum deliberately wraps modulo 2**AW
   logic [AW-1:0] slot_addr;
   assign slot_addr = BASE_ADDR + AW'(idx_reg);

   logic          busy_next_out;
   logic          done_out;
   logic [IW-1:0] n1_out, nd_out;
   logic [DW-1:0] di_out, mem_do_out;
   logic [AW-1:0] mem_addr_out;
   logic          reg_we_out, mem_we_out, mem_re_out;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      busy_next_out = 1'b1;
      done_out      = 1'b0;
      n1_out        = '0;
      nd_out        = '0;
      di_out        = '0;
      mem_do_out    = '0;
      mem_addr_out  = '0;
      reg_we_out    = 1'b0;
      mem_we_out    = 1'b0;
      mem_re_out    = 1'b0;

      case (state_reg)
         IDLE: begin
            busy_next_out = 1'b0;
            // save has priority; a simultaneous restore request is dropped
            if (bus.save_req) begin
               state_next = SAVE;
               idx_next   = '0;
            end else if (bus.restore_req) begin
               state_next = RST_RD;
               idx_next   = '0;
            end
         end

         SAVE: begin
            n1_out       = idx_reg;
            mem_addr_out = slot_addr;
            mem_do_out   = bus.q1;
            mem_we_out   = 1'b1;
            if (idx_reg == LAST_IDX) begin
               state_next = FIN;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end

         RST_RD: begin
            mem_addr_out = slot_addr;
            mem_re_out   = 1'b1;
            state_next   = RST_WR;
         end

         RST_WR: begin
            // memory data arrives one cycle after the read strobe
            nd_out     = idx_reg;
            di_out     = bus.mem_di;
            reg_we_out = 1'b1;
            if (idx_reg == LAST_IDX) begin
               state_next = FIN;
            end else begin
               idx_next   = idx_reg + 1'b1;
               state_next = RST_RD;
            end
         end

         FIN: begin
            done_out   = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   assign bus.busy     = busy_next_out;
   assign bus.done     = done_out;
   assign bus.n1       = n1_out;
   assign bus.nd       = nd_out;
   assign bus.di       = di_out;
   assign bus.reg_we   = reg_we_out;
   assign bus.mem_addr = mem_addr_out;
   assign bus.mem_do   = mem_do_out;
   assign bus.mem_we   = mem_we_out;
   assign bus.mem_re   = mem_re_out;

endmodule

// File: tb/tb_reg_ctx_seq.sv
// ---------------------------------------------------------------------------
// tb_reg_ctx_seq
// Two sequencer instances (save area at F0 and at FE) each driving a small
// register file and memory model. Stimulus pushes the expected transactions
// (memory writes, memory reads, register writes, done with busy length) into
// a scoreboard queue; monitors pop and compare whenever a strobe or done is
// seen on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_reg_ctx_seq;

   localparam logic [1:0] K_MWR  = 2'd0;
   localparam logic [1:0] K_MRD  = 2'd1;
   localparam logic [1:0] K_RWR  = 2'd2;
   localparam logic [1:0] K_DONE = 2'd3;

   typedef struct packed {
      logic       dut;
      logic [1:0] kind;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   int   busy_a = 0;
   int   busy_b = 0;

   reg_ctx_seq_if #(.DW(8), .IW(2), .AW(8)) bus_a ();
   reg_ctx_seq_if #(.DW(8), .IW(2), .AW(8)) bus_b ();

   reg_ctx_seq #(.DW(8), .IW(2), .AW(8), .BASE(8'hF0)) dut_a (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus_a)
   );

   reg_ctx_seq #(.DW(8), .IW(2), .AW(8), .BASE(8'hFE)) dut_b (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- register file / memory models ----------------
   logic [7:0] rf_a [4];
   logic [7:0] rf_b [4];
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] ld_v [4];
   logic       ld_rf_a = 1'b0, ld_mem_a = 1'b0, ld_rf_b = 1'b0;

   assign bus_a.q1 = rf_a[bus_a.n1];
   assign bus_b.q1 = rf_b[bus_b.n1];

   always @(posedge clk) begin
      if (ld_rf_a) for (int i = 0; i < 4; i++) rf_a[i] <= ld_v[i];
      if (ld_mem_a) for (int i = 0; i < 4; i++) mem_a[8'hF0 + i] <= ld_v[i];
      if (bus_a.reg_we) rf_a[bus_a.nd] <= bus_a.di;
      if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_do;
      if (bus_a.mem_re) bus_a.mem_di <= mem_a[bus_a.mem_addr];
   end

   always @(posedge clk) begin
      if (ld_rf_b) for (int i = 0; i < 4; i++) rf_b[i] <= ld_v[i];
      if (bus_b.reg_we) rf_b[bus_b.nd] <= bus_b.di;
      if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_do;
      if (bus_b.mem_re) bus_b.mem_di <= mem_b[bus_b.mem_addr];
   end

   // ---------------- scoreboard ----------------
   task automatic expect_tr(input logic dut, input logic [1:0] kind,
                            input logic [7:0] addr, input logic [7:0] data);
      exp_t e;
      e.dut = dut; e.kind = kind; e.addr = addr; e.data = data;
      q.push_back(e);
   endtask

   task automatic score(input logic dut, input logic [1:0] kind,
                        input logic [7:0] addr, input logic [7:0] data,
                        input string name);
      exp_t g, e;
      g.dut = dut; g.kind = kind; g.addr = addr; g.data = data;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL %s: got dut=%0d kind=%0d addr=%h data=%h, required no transaction",
                  name, dut, kind, addr, data);
      end else begin
         e = q.pop_front();
         if (g !== e) begin
            errors++;
            $display("FAIL %s: got dut=%0d kind=%0d addr=%h data=%h, required dut=%0d kind=%0d addr=%h data=%h",
                     name, dut, kind, addr, data, e.dut, e.kind, e.addr, e.data);
         end else begin
            $display("ok   %s: dut=%0d addr=%h data=%h", name, dut, addr, data);
         end
      end
   endtask

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end else begin
         $display("ok   %s: %0h", name, got);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_a = 0;
      end else begin
         if (bus_a.busy) busy_a++;
         if (bus_a.mem_we || bus_a.mem_re || bus_a.reg_we)
            check("a_one_strobe", int'(bus_a.mem_we) + int'(bus_a.mem_re) + int'(bus_a.reg_we), 1);
         if (bus_a.mem_we) score(1'b0, K_MWR, bus_a.mem_addr, bus_a.mem_do, "a_mem_wr");
         if (bus_a.mem_re) score(1'b0, K_MRD, bus_a.mem_addr, bus_a.mem_do, "a_mem_rd");
         if (bus_a.reg_we) score(1'b0, K_RWR, 8'(bus_a.nd), bus_a.di, "a_reg_wr");
         if (bus_a.done) begin
            score(1'b0, K_DONE, 8'h00, 8'(busy_a), "a_done");
            busy_a = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_b = 0;
      end else begin
         if (bus_b.busy) busy_b++;
         if (bus_b.mem_we) score(1'b1, K_MWR, bus_b.mem_addr, bus_b.mem_do, "b_mem_wr");
         if (bus_b.mem_re) score(1'b1, K_MRD, bus_b.mem_addr, bus_b.mem_do, "b_mem_rd");
         if (bus_b.reg_we) score(1'b1, K_RWR, 8'(bus_b.nd), bus_b.di, "b_reg_wr");
         if (bus_b.done) begin
            score(1'b1, K_DONE, 8'h00, 8'(busy_b), "b_done");
            busy_b = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load(input int target, input logic [7:0] v0, input logic [7:0] v1,
                       input logic [7:0] v2, input logic [7:0] v3);
      @(negedge clk);
      ld_v[0] = v0; ld_v[1] = v1; ld_v[2] = v2; ld_v[3] = v3;
      ld_rf_a  = (target == 0);
      ld_mem_a = (target == 1);
      ld_rf_b  = (target == 2);
      @(negedge clk);
      ld_rf_a = 1'b0; ld_mem_a = 1'b0; ld_rf_b = 1'b0;
   endtask

   task automatic expect_save(input logic dut, input logic [7:0] base,
                              input logic [7:0] v0, input logic [7:0] v1,
                              input logic [7:0] v2, input logic [7:0] v3);
      expect_tr(dut, K_MWR, base,         v0);
      expect_tr(dut, K_MWR, base + 8'd1,  v1);
      expect_tr(dut, K_MWR, base + 8'd2,  v2);
      expect_tr(dut, K_MWR, base + 8'd3,  v3);
      expect_tr(dut, K_DONE, 8'h00, 8'd5);
   endtask

   task automatic expect_restore(input logic [7:0] v0, input logic [7:0] v1,
                                 input logic [7:0] v2, input logic [7:0] v3);
      expect_tr(1'b0, K_MRD, 8'hF0, 8'h00); expect_tr(1'b0, K_RWR, 8'd0, v0);
      expect_tr(1'b0, K_MRD, 8'hF1, 8'h00); expect_tr(1'b0, K_RWR, 8'd1, v1);
      expect_tr(1'b0, K_MRD, 8'hF2, 8'h00); expect_tr(1'b0, K_RWR, 8'd2, v2);
      expect_tr(1'b0, K_MRD, 8'hF3, 8'h00); expect_tr(1'b0, K_RWR, 8'd3, v3);
      expect_tr(1'b0, K_DONE, 8'h00, 8'd9);
   endtask

   // which: 0 = save on a, 1 = restore on a, 2 = both on a, 3 = save on b
   task automatic pulse(input int which);
      @(negedge clk);
      bus_a.save_req    = (which == 0 || which == 2);
      bus_a.restore_req = (which == 1 || which == 2);
      bus_b.save_req    = (which == 3);
      @(negedge clk);
      bus_a.save_req = 1'b0; bus_a.restore_req = 1'b0; bus_b.save_req = 1'b0;
   endtask

   task automatic wait_done(input logic dut, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(dut ? bus_b.done : bus_a.done) && n < 40);
      if (!(dut ? bus_b.done : bus_a.done)) begin
         checks++;
         errors++;
         $display("FAIL %s: done not seen within 40 cycles, required a done pulse", name);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n = 1'b0;
      bus_a.save_req = 1'b0; bus_a.restore_req = 1'b0;
      bus_b.save_req = 1'b0; bus_b.restore_req = 1'b0;
      #2;
      check("reset_outputs_a",
            int'({bus_a.busy, bus_a.done, bus_a.reg_we, bus_a.mem_we, bus_a.mem_re,
                  bus_a.n1, bus_a.nd, bus_a.di, bus_a.mem_addr, bus_a.mem_do}), 0);
      check("reset_outputs_b",
            int'({bus_b.busy, bus_b.done, bus_b.reg_we, bus_b.mem_we, bus_b.mem_re,
                  bus_b.mem_addr}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: save 11,22,33,44 to F0..F3, busy 5 cycles
      load(0, 8'h11, 8'h22, 8'h33, 8'h44);
      expect_save(1'b0, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44);
      pulse(0);
      wait_done(1'b0, "t1_done");
      @(negedge clk);
      check("t1_idle_busy", int'(bus_a.busy), 0);

      // 2: restore A1..D4 from F0..F3, busy 9 cycles
      load(1, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      expect_restore(8'hA1, 8'hB2, 8'hC3, 8'hD4);
      pulse(1);
      wait_done(1'b0, "t2_done");
      @(negedge clk);
      check("t2_r0", int'(rf_a[0]), 'hA1);
      check("t2_r1", int'(rf_a[1]), 'hB2);
      check("t2_r2", int'(rf_a[2]), 'hC3);
      check("t2_r3", int'(rf_a[3]), 'hD4);

      // 3: both requests together -> save only
      load(0, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
      expect_save(1'b0, 8'hF0, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
      pulse(2);
      wait_done(1'b0, "t3_done");
      repeat (3) @(negedge clk);
      check("t3_no_restore_busy", int'(bus_a.busy), 0);

      // 4: save area at FE wraps FE,FF,00,01
      load(2, 8'h01, 8'h02, 8'h03, 8'h04);
      expect_save(1'b1, 8'hFE, 8'h01, 8'h02, 8'h03, 8'h04);
      pulse(3);
      wait_done(1'b1, "t4_done");
      @(negedge clk);

      // 5: reset during the second register write of a restore
      load(1, 8'h10, 8'h20, 8'h30, 8'h40);
      expect_tr(1'b0, K_MRD, 8'hF0, 8'h00);
      expect_tr(1'b0, K_RWR, 8'd0, 8'h10);
      expect_tr(1'b0, K_MRD, 8'hF1, 8'h00);
      pulse(1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_strobes_drop",
            int'({bus_a.busy, bus_a.done, bus_a.reg_we, bus_a.mem_we, bus_a.mem_re}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_r0", int'(rf_a[0]), 'h10);
      check("t5_r1", int'(rf_a[1]), 'h6B);
      check("t5_r2", int'(rf_a[2]), 'h7C);
      check("t5_r3", int'(rf_a[3]), 'h8D);
      expect_restore(8'h10, 8'h20, 8'h30, 8'h40);
      pulse(1);
      wait_done(1'b0, "t5_restart_done");
      @(negedge clk);
      check("t5_restart_r3", int'(rf_a[3]), 'h40);

      // 6: save request held through a whole save -> one sequence
      expect_save(1'b0, 8'hF0, 8'h10, 8'h20, 8'h30, 8'h40);
      @(negedge clk);
      bus_a.save_req = 1'b1;
      wait_done(1'b0, "t6_done");
      bus_a.save_req = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_idle_busy", int'(bus_a.busy), 0);

      check("scoreboard_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
